// File: rtl/twos_deser.sv
// Serial-to-parallel collector: assembles LSB-first WIDTH-bit frames marked by sof
// into a held output word behind a valid/ready handshake, with sticky error flags.
module twos_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sof,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             ovf,
  output logic             ferr
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             valid_nxt;
  logic             ovf_nxt;
  logic             ferr_nxt;
  logic             done;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  // State, collector and output registers
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      busy       <= (state_nxt == SHIFT);
      ovf        <= ovf_nxt;
      ferr       <= ferr_nxt;
    end
  end

  // Next-state, collector update, completion handshake and flags
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    done      = 1'b0;
    dout_nxt  = dout;
    valid_nxt = dout_valid;
    ovf_nxt   = clr ? 1'b0 : ovf;
    ferr_nxt  = clr ? 1'b0 : ferr;
    // New bit enters at the MSB; the whole register moves one place right
    shifted   = WIDTH'({sin, sreg} >> 1);
    first     = {sin, (WIDTH-1)'(0)};

    case (state)
      IDLE: begin
        if (sin_en && sof) begin
          sreg_nxt  = first;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_en) begin
          if (sof) begin
            // Restart: partial word discarded, this beat is bit 0
            ferr_nxt = 1'b1;
            sreg_nxt = first;
            cnt_nxt  = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            sreg_nxt  = shifted;
            cnt_nxt   = '0;
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            sreg_nxt = shifted;
            cnt_nxt  = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (done) begin
      if (!dout_valid || dout_ready) begin
        dout_nxt  = shifted;
        valid_nxt = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_twos_deser.sv
// Directed bench for twos_deser: expected words are queued by stimulus and
// checked by a handshake monitor; flags and status are checked directly.
module tb_twos_deser;

  localparam int unsigned WIDTH = 8;

  logic             t_clk = 1'b0;
  logic             r_n;
  logic             sin;
  logic             sin_en;
  logic             sof;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             ovf;
  logic             ferr;

  int n_checks = 0;
  int n_fails  = 0;
  logic [WIDTH-1:0] exp_q[$];

  twos_deser #(.WIDTH(WIDTH)) dut (
    .t_clk      (t_clk),
    .r_n        (r_n),
    .sin        (sin),
    .sin_en     (sin_en),
    .sof        (sof),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .ovf        (ovf),
    .ferr       (ferr)
  );

  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word must match the head of the queue
  always @(negedge t_clk) begin
    if (r_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_fails++;
          $display("FAIL word: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge t_clk);
      #1;
    end
  endtask

  task automatic beat(input logic b, input logic s);
    sin    = b;
    sof    = s;
    sin_en = 1'b1;
    @(posedge t_clk);
    #1;
    sin_en = 1'b0;
    sof    = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    for (int i = 0; i < int'(WIDTH); i++) beat(w[i], i == 0);
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    r_n = 1'b0; sin = 1'b0; sin_en = 1'b0; sof = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    idle(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    r_n = 1'b1;
    idle(1);

    // Frame 0xFB held with no consumer
    exp_q.push_back(8'hFB);
    beat(1'b1, 1'b1);
    check("busy_after_sof", 32'(busy), 32'h1);
    w = 8'hFB;
    for (int i = 1; i < 8; i++) beat(w[i], 1'b0);
    check("fb_dout", 32'(dout), 32'hFB);
    check("fb_valid", 32'(dout_valid), 32'h1);
    check("fb_busy", 32'(busy), 32'h0);
    consume();
    check("fb_consumed_valid", 32'(dout_valid), 32'h0);
    check("fb_dout_kept", 32'(dout), 32'hFB);

    // 0x80 with gaps between beats
    exp_q.push_back(8'h80);
    w = 8'h80;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("gap_valid_before_last", 32'(dout_valid), 32'h0);
      beat(w[i], i == 0);
      idle(2);
    end
    check("gap_dout", 32'(dout), 32'h80);
    check("gap_valid", 32'(dout_valid), 32'h1);
    consume();

    // Overflow: 0x11 held, 0x22 dropped
    exp_q.push_back(8'h11);
    send(8'h11);
    send(8'h22);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_dout", 32'(dout), 32'h11);
    check("ovf_valid", 32'(dout_valid), 32'h1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'h0);
    consume();

    // Framing error: 3 bits then a new sof frame 0x5A
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    check("ferr_before", 32'(ferr), 32'h0);
    exp_q.push_back(8'h5A);
    send(8'h5A);
    check("ferr_set", 32'(ferr), 32'h1);
    check("ferr_dout", 32'(dout), 32'h5A);
    check("ferr_valid", 32'(dout_valid), 32'h1);
    consume();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("ferr_clr", 32'(ferr), 32'h0);

    // Completion and consume on the same edge, back-to-back frames
    exp_q.push_back(8'h33);
    send(8'h33);
    exp_q.push_back(8'h44);
    w = 8'h44;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) dout_ready = 1'b1;
      beat(w[i], i == 0);
    end
    dout_ready = 1'b0;
    check("swap_dout", 32'(dout), 32'h44);
    check("swap_valid", 32'(dout_valid), 32'h1);
    check("swap_ovf", 32'(ovf), 32'h0);
    consume();

    // Reset in the middle of a frame
    w = 8'hFF;
    for (int i = 0; i < 5; i++) beat(w[i], i == 0);
    check("mid_busy", 32'(busy), 32'h1);
    r_n = 1'b0;
    idle(2);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(dout_valid), 32'h0);
    r_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    check("nosof_busy", 32'(busy), 32'h0);
    exp_q.push_back(8'h01);
    send(8'h01);
    check("post_rst_dout", 32'(dout), 32'h01);
    check("post_rst_flags", 32'({ovf, ferr}), 32'h0);
    consume();

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
